// File: rtl/vga_grid_scan.sv
// Single-clock VGA scan generator with a pixel-tick enable and a two-stage tile-grid renderer.
// The tile map is read through a one-cycle lookup port; an apple tile is latched once per frame.
module vga_grid_scan #(
    parameter int unsigned       CLK_DIV      = 4,
    parameter int unsigned       H_ACTIVE     = 640,
    parameter int unsigned       H_FP         = 16,
    parameter int unsigned       H_SYNC       = 96,
    parameter int unsigned       H_BP         = 48,
    parameter int unsigned       V_ACTIVE     = 480,
    parameter int unsigned       V_FP         = 10,
    parameter int unsigned       V_SYNC       = 2,
    parameter int unsigned       V_BP         = 33,
    parameter bit                SYNC_POL     = 1'b0,
    parameter int unsigned       TILE_LOG2    = 4,
    parameter int unsigned       GRID_W       = 40,
    parameter int unsigned       GRID_H       = 30,
    parameter int unsigned       COLOR_W      = 16,
    parameter logic [COLOR_W-1:0] COLOR_BG     = COLOR_W'(16'h0000),
    parameter logic [COLOR_W-1:0] COLOR_BODY   = COLOR_W'(16'h07E0),
    parameter logic [COLOR_W-1:0] COLOR_HEAD   = COLOR_W'(16'h03E0),
    parameter logic [COLOR_W-1:0] COLOR_WALL   = COLOR_W'(16'h8410),
    parameter logic [COLOR_W-1:0] COLOR_APPLE  = COLOR_W'(16'hF800),
    parameter logic [COLOR_W-1:0] COLOR_BORDER = COLOR_W'(16'h001F)
) (
    input  logic               clk,
    input  logic               rst,
    output logic [5:0]         tile_x,
    output logic [4:0]         tile_y,
    input  logic [1:0]         tile_kind,
    input  logic [5:0]         apple_x,
    input  logic [4:0]         apple_y,
    output logic [9:0]         x_pos,
    output logic [9:0]         y_pos,
    output logic               hsync,
    output logic               vsync,
    output logic [COLOR_W-1:0] color_out,
    output logic               pixel_valid,
    output logic               frame_start
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned DIV_W   = $clog2(CLK_DIV);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [DIV_W-1:0] div_q;
    logic [9:0]       hc_q, vc_q;
    logic             pix_tick;

    // Stage-1 registers travelling alongside the tile lookup
    logic [9:0] hc1_q, vc1_q;
    logic       act1_q, grid1_q, hs1_q, vs1_q;

    logic [5:0] apple_x_q;
    logic [4:0] apple_y_q;

    logic [5:0]         tx_c;
    logic [4:0]         ty_c;
    logic               act_c, grid_c, hs_c, vs_c;
    logic [COLOR_W-1:0] color_d;

    assign pix_tick    = (div_q == DIV_LAST);
    assign frame_start = pix_tick && (hc_q == 10'd0) && (vc_q == 10'd0);

    always_comb begin
        tx_c   = 6'(hc_q >> TILE_LOG2);
        ty_c   = 5'(vc_q >> TILE_LOG2);
        act_c  = (hc_q < 10'(H_ACTIVE)) && (vc_q < 10'(V_ACTIVE));
        grid_c = (32'(tx_c) < GRID_W) && (32'(ty_c) < GRID_H);
        hs_c   = (hc_q >= HS_START && hc_q < HS_END) ? SYNC_POL : ~SYNC_POL;
        vs_c   = (vc_q >= VS_START && vc_q < VS_END) ? SYNC_POL : ~SYNC_POL;
    end

    // An out-of-range apple can only coincide with an out-of-grid tile, which takes the border
    always_comb begin
        color_d = '0;
        if (!act1_q) begin
            color_d = '0;
        end else if (!grid1_q) begin
            color_d = COLOR_BORDER;
        end else if (tile_x == apple_x_q && tile_y == apple_y_q) begin
            color_d = COLOR_APPLE;
        end else begin
            unique case (tile_kind)
                2'd0: color_d = COLOR_BG;
                2'd1: color_d = COLOR_BODY;
                2'd2: color_d = COLOR_HEAD;
                2'd3: color_d = COLOR_WALL;
                default: color_d = COLOR_BG;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q       <= '0;
            hc_q        <= '0;
            vc_q        <= '0;
            tile_x      <= '0;
            tile_y      <= '0;
            hc1_q       <= '0;
            vc1_q       <= '0;
            act1_q      <= 1'b0;
            grid1_q     <= 1'b0;
            hs1_q       <= ~SYNC_POL;
            vs1_q       <= ~SYNC_POL;
            x_pos       <= '0;
            y_pos       <= '0;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            color_out   <= '0;
            pixel_valid <= 1'b0;
            apple_x_q   <= '0;
            apple_y_q   <= '0;
        end else begin
            div_q <= pix_tick ? '0 : div_q + DIV_W'(1);
            if (pix_tick) begin
                if (hc_q == H_LAST) begin
                    hc_q <= '0;
                    vc_q <= (vc_q == V_LAST) ? 10'd0 : vc_q + 10'd1;
                end else begin
                    hc_q <= hc_q + 10'd1;
                end

                tile_x  <= tx_c;
                tile_y  <= ty_c;
                hc1_q   <= hc_q;
                vc1_q   <= vc_q;
                act1_q  <= act_c;
                grid1_q <= grid_c;
                hs1_q   <= hs_c;
                vs1_q   <= vs_c;

                color_out   <= color_d;
                pixel_valid <= act1_q;
                x_pos       <= hc1_q;
                y_pos       <= vc1_q;
                hsync       <= hs1_q;
                vsync       <= vs1_q;

                if (frame_start) begin
                    apple_x_q <= apple_x;
                    apple_y_q <= apple_y;
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_grid_scan.sv
// Bench for vga_grid_scan: a pixel-index model predicts every output each clock, plus literal
// spot checks on a deterministic map and randomized map/apple traffic.
module tb_vga_grid_scan;

    localparam int CLK_DIV   = 3;
    localparam int H_ACTIVE  = 64;
    localparam int H_FP      = 4;
    localparam int H_SYNC    = 8;
    localparam int H_BP      = 4;
    localparam int V_ACTIVE  = 48;
    localparam int V_FP      = 2;
    localparam int V_SYNC    = 2;
    localparam int V_BP      = 4;
    localparam int TILE_LOG2 = 3;
    localparam int GRID_W    = 6;
    localparam int GRID_H    = 5;
    localparam int H_TOT     = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT     = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int FRAME     = H_TOT * V_TOT;

    localparam logic [15:0] C_BG     = 16'h0821;
    localparam logic [15:0] C_BODY   = 16'h07E0;
    localparam logic [15:0] C_HEAD   = 16'h03E0;
    localparam logic [15:0] C_WALL   = 16'h8410;
    localparam logic [15:0] C_APPLE  = 16'hF800;
    localparam logic [15:0] C_BORDER = 16'h001F;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  tile_x;
    logic [4:0]  tile_y;
    logic [1:0]  tile_kind;
    logic [5:0]  apple_x;
    logic [4:0]  apple_y;
    logic [9:0]  x_pos, y_pos;
    logic        hsync, vsync, pixel_valid, frame_start;
    logic [15:0] color_out;

    logic [1:0]  kind_tab [0:63][0:31];
    logic [10:0] apple_hist [0:15];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n     = 0;
    bit started = 1'b0;

    always #5 clk = ~clk;

    assign tile_kind = kind_tab[tile_x][tile_y];

    vga_grid_scan #(
        .CLK_DIV(CLK_DIV), .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP), .SYNC_POL(1'b0),
        .TILE_LOG2(TILE_LOG2), .GRID_W(GRID_W), .GRID_H(GRID_H), .COLOR_W(16),
        .COLOR_BG(C_BG), .COLOR_BODY(C_BODY), .COLOR_HEAD(C_HEAD), .COLOR_WALL(C_WALL),
        .COLOR_APPLE(C_APPLE), .COLOR_BORDER(C_BORDER)
    ) dut (
        .clk(clk), .rst(rst), .tile_x(tile_x), .tile_y(tile_y), .tile_kind(tile_kind),
        .apple_x(apple_x), .apple_y(apple_y), .x_pos(x_pos), .y_pos(y_pos),
        .hsync(hsync), .vsync(vsync), .color_out(color_out), .pixel_valid(pixel_valid),
        .frame_start(frame_start)
    );

    function automatic logic [15:0] pal(input logic [1:0] k);
        case (k)
            2'd0: return C_BG;
            2'd1: return C_BODY;
            2'd2: return C_HEAD;
            default: return C_WALL;
        endcase
    endfunction

    // Model: n counts pixel ticks since reset; tick n+1 carries counter index n
    initial forever begin
        @(posedge clk);
        if (rst) begin
            started = 1'b1;
            cyc = 0;
            n = 0;
        end else begin
            if (cyc % CLK_DIV == CLK_DIV - 1) begin
                if (n % FRAME == 0) apple_hist[(n / FRAME) % 16] = {apple_x, apple_y};
                n++;
            end
            cyc++;
        end
    end

    // Per-cycle comparison: outputs show the pixel with index n-2, tile port shows index n-1
    initial begin : compare
        int p, hc, vc, f, tx, ty, q, ax, ay, ex, ey, etx, ety;
        logic [15:0] ec;
        bit ev, ehs, evs, efs;
        forever begin
            @(negedge clk);
            if (started) begin
                efs = (cyc % CLK_DIV == CLK_DIV - 1) && (n % FRAME == 0);
                if (n < 2) begin
                    ec = 16'h0; ex = 0; ey = 0; ev = 1'b0; ehs = 1'b1; evs = 1'b1;
                end else begin
                    p  = n - 2;
                    hc = p % H_TOT;
                    vc = (p / H_TOT) % V_TOT;
                    f  = p / FRAME;
                    ex = hc;
                    ey = vc;
                    ev = (hc < H_ACTIVE) && (vc < V_ACTIVE);
                    tx = hc / (1 << TILE_LOG2);
                    ty = vc / (1 << TILE_LOG2);
                    ax = int'(apple_hist[f % 16][10:5]);
                    ay = int'(apple_hist[f % 16][4:0]);
                    if (!ev) ec = 16'h0;
                    else if (tx >= GRID_W || ty >= GRID_H) ec = C_BORDER;
                    else if (tx == ax && ty == ay) ec = C_APPLE;
                    else ec = pal(kind_tab[tx][ty]);
                    ehs = !(hc >= H_ACTIVE + H_FP && hc < H_ACTIVE + H_FP + H_SYNC);
                    evs = !(vc >= V_ACTIVE + V_FP && vc < V_ACTIVE + V_FP + V_SYNC);
                end
                if (n < 1) begin
                    etx = 0; ety = 0;
                end else begin
                    q   = n - 1;
                    etx = (q % H_TOT) / (1 << TILE_LOG2);
                    ety = ((q / H_TOT) % V_TOT) / (1 << TILE_LOG2);
                end
                total++;
                if (color_out !== ec || int'(x_pos) != ex || int'(y_pos) != ey ||
                    pixel_valid !== ev || hsync !== ehs || vsync !== evs ||
                    frame_start !== efs || int'(tile_x) != etx || int'(tile_y) != ety) begin
                    bad++;
                    $display("FAIL cycle t=%0t got col=%h x=%0d y=%0d v=%b hs=%b vs=%b fs=%b tx=%0d ty=%0d want col=%h x=%0d y=%0d v=%b hs=%b vs=%b fs=%b tx=%0d ty=%0d",
                             $time, color_out, x_pos, y_pos, pixel_valid, hsync, vsync,
                             frame_start, tile_x, tile_y, ec, ex, ey, ev, ehs, evs, efs, etx, ety);
                end
            end
        end
    end

    task automatic chk(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic wait_pix(input int x, input int y);
        for (int k = 0; k < 20000; k++) begin
            @(negedge clk);
            if (int'(x_pos) == x && int'(y_pos) == y) return;
        end
        total++;
        bad++;
        $display("FAIL wait_pix(%0d,%0d) got=timeout want=reached", x, y);
    endtask

    initial begin
        apple_x = 6'd1;
        apple_y = 5'd2;
        for (int i = 0; i < 64; i++)
            for (int j = 0; j < 32; j++) kind_tab[i][j] = 2'((i + j) % 4);

        repeat (5) @(negedge clk);
        chk("rst_color", int'(color_out), 0);
        chk("rst_hsync", int'(hsync), 1);
        chk("rst_valid", int'(pixel_valid), 0);
        rst = 1'b0;

        repeat (2) @(negedge clk);
        chk("first_frame_start", int'(frame_start), 1);
        repeat (3) @(negedge clk);
        chk("pix0_not_yet", int'(pixel_valid), 0);
        @(negedge clk);
        chk("pix0_valid", int'(pixel_valid), 1);
        chk("pix0_x", int'(x_pos), 0);
        chk("pix0_y", int'(y_pos), 0);
        chk("pix0_color", int'(color_out), int'(C_BG));

        wait_pix(8, 0);   chk("body_8_0", int'(color_out), int'(C_BODY));
        wait_pix(70, 0);
        chk("blank_color", int'(color_out), 0);
        chk("blank_valid", int'(pixel_valid), 0);
        chk("hsync_on", int'(hsync), 0);
        wait_pix(0, 10);
        apple_x = 6'd2;   // mid-frame move, must not show until next frame
        apple_y = 5'd2;
        wait_pix(12, 20); chk("apple_over_wall", int'(color_out), int'(C_APPLE));
        wait_pix(20, 20); chk("old_frame_bg", int'(color_out), int'(C_BG));
        wait_pix(17, 33); chk("head_17_33", int'(color_out), int'(C_HEAD));
        wait_pix(40, 44); chk("border_row", int'(color_out), int'(C_BORDER));
        wait_pix(63, 47); chk("border_corner", int'(color_out), int'(C_BORDER));
        wait_pix(0, 50);
        chk("vsync_on", int'(vsync), 0);
        chk("vblank_valid", int'(pixel_valid), 0);
        wait_pix(12, 20); chk("next_frame_wall", int'(color_out), int'(C_WALL));
        wait_pix(20, 20); chk("next_frame_apple", int'(color_out), int'(C_APPLE));

        repeat ($urandom_range(100, 1500)) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 64; i++)
            for (int j = 0; j < 32; j++) kind_tab[i][j] = 2'($urandom_range(0, 3));
        repeat (5) @(negedge clk);
        chk("midrst_x", int'(x_pos), 0);
        chk("midrst_tile_x", int'(tile_x), 0);
        chk("midrst_vsync", int'(vsync), 1);
        rst = 1'b0;

        for (int it = 0; it < 25; it++) begin
            repeat ($urandom_range(500, 2500)) @(negedge clk);
            apple_x = 6'($urandom_range(0, 7));
            apple_y = 5'($urandom_range(0, 6));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
